// File: rtl/pc_seq_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_seq_ctr : multi-cycle fetch/execute sequencer owning the architectural |
// | PC, with retire pulses, instret counter and halt/fault status.            |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module pc_seq_ctr #(
    parameter int unsigned     DW       = 64,
    parameter logic [DW-1:0]   RESET_PC = DW'(64'h8000_0000),
    parameter int unsigned     IW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    output logic          if_req_valid_o,
    input  logic          if_req_ready_i,
    output logic [DW-1:0] if_req_addr_o,
    input  logic          if_rsp_valid_i,
    input  logic [IW-1:0] if_rsp_inst_i,
    input  logic          if_rsp_err_i,
    output logic          id_inst_valid_o,
    output logic [IW-1:0] id_inst_o,
    output logic [DW-1:0] id_pc_o,
    input  logic          ex_done_i,
    input  logic          bc_branch_flag_i,
    input  logic [DW-1:0] bc_branch_dnpc_i,
    input  logic          trap_valid_i,
    input  logic [DW-1:0] trap_pc_i,
    input  logic          halt_i,
    output logic          retire_o,
    output logic [DW-1:0] retire_pc_o,
    output logic [63:0]   instret_o,
    output logic          halted_o,
    output logic          fault_o,
    output logic [DW-1:0] fault_pc_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [IW-1:0] inst_q, inst_d;
    logic          retire_q, retire_d;
    logic [DW-1:0] retire_pc_q, retire_pc_d;
    logic [63:0]   instret_q, instret_d;
    logic          fault_q, fault_d;
    logic [DW-1:0] fault_pc_q, fault_pc_d;

    logic [DW-1:0] w_next_pc;
    logic          w_misaligned;

    // Trap redirect outranks branch resolution, which outranks sequential flow.
    assign w_next_pc    = trap_valid_i     ? trap_pc_i        :
                          bc_branch_flag_i ? bc_branch_dnpc_i :
                                             pc_q + DW'(4);
    assign w_misaligned = (w_next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            retire_q    <= 1'b0;
            retire_pc_q <= '0;
            instret_q   <= '0;
            fault_q     <= 1'b0;
            fault_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            retire_q    <= retire_d;
            retire_pc_q <= retire_pc_d;
            instret_q   <= instret_d;
            fault_q     <= fault_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        retire_d    = 1'b0;
        retire_pc_d = retire_pc_q;
        instret_d   = instret_q;
        fault_d     = fault_q;
        fault_pc_d  = fault_pc_q;

        case (state_q)
            S_REQ: begin
                if (if_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (if_rsp_valid_i) begin
                    if (if_rsp_err_i) begin
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                        state_d    = S_HALT;
                    end else begin
                        inst_d  = if_rsp_inst_i;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (ex_done_i) begin
                    retire_d    = 1'b1;
                    retire_pc_d = pc_q;
                    instret_d   = instret_q + 64'd1;
                    // A misaligned redirect still retires but leaves pc at the culprit.
                    if (w_misaligned) begin
                        fault_d    = 1'b1;
                        fault_pc_d = w_next_pc;
                        state_d    = S_HALT;
                    end else begin
                        pc_d    = w_next_pc;
                        state_d = halt_i ? S_HALT : S_REQ;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign if_req_valid_o  = !rst && (state_q == S_REQ);
    assign if_req_addr_o   = pc_q;
    assign id_inst_valid_o = !rst && (state_q == S_EXEC);
    assign id_inst_o       = inst_q;
    assign id_pc_o         = pc_q;
    assign retire_o        = retire_q;
    assign retire_pc_o     = retire_pc_q;
    assign instret_o       = instret_q;
    assign halted_o        = (state_q == S_HALT);
    assign fault_o         = fault_q;
    assign fault_pc_o      = fault_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_seq_ctr : directed self-checking bench for pc_seq_ctr.              |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_pc_seq_ctr;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid_o;
    logic        if_req_ready_i;
    logic [63:0] if_req_addr_o;
    logic        if_rsp_valid_i;
    logic [31:0] if_rsp_inst_i;
    logic        if_rsp_err_i;
    logic        id_inst_valid_o;
    logic [31:0] id_inst_o;
    logic [63:0] id_pc_o;
    logic        ex_done_i;
    logic        bc_branch_flag_i;
    logic [63:0] bc_branch_dnpc_i;
    logic        trap_valid_i;
    logic [63:0] trap_pc_i;
    logic        halt_i;
    logic        retire_o;
    logic [63:0] retire_pc_o;
    logic [63:0] instret_o;
    logic        halted_o;
    logic        fault_o;
    logic [63:0] fault_pc_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_seq_ctr dut (
        .clk              (clk),
        .rst              (rst),
        .if_req_valid_o   (if_req_valid_o),
        .if_req_ready_i   (if_req_ready_i),
        .if_req_addr_o    (if_req_addr_o),
        .if_rsp_valid_i   (if_rsp_valid_i),
        .if_rsp_inst_i    (if_rsp_inst_i),
        .if_rsp_err_i     (if_rsp_err_i),
        .id_inst_valid_o  (id_inst_valid_o),
        .id_inst_o        (id_inst_o),
        .id_pc_o          (id_pc_o),
        .ex_done_i        (ex_done_i),
        .bc_branch_flag_i (bc_branch_flag_i),
        .bc_branch_dnpc_i (bc_branch_dnpc_i),
        .trap_valid_i     (trap_valid_i),
        .trap_pc_i        (trap_pc_i),
        .halt_i           (halt_i),
        .retire_o         (retire_o),
        .retire_pc_o      (retire_pc_o),
        .instret_o        (instret_o),
        .halted_o         (halted_o),
        .fault_o          (fault_o),
        .fault_pc_o       (fault_pc_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake in REQ, then respond one cycle later.
    task automatic fetch(input logic [31:0] inst, input logic err);
        if_req_ready_i = 1'b1;
        tick();
        if_req_ready_i = 1'b0;
        if_rsp_valid_i = 1'b1;
        if_rsp_inst_i  = inst;
        if_rsp_err_i   = err;
        tick();
        if_rsp_valid_i = 1'b0;
        if_rsp_err_i   = 1'b0;
    endtask

    task automatic execute(input logic flag, input logic [63:0] dnpc,
                           input logic trap, input logic [63:0] tpc, input logic hlt);
        ex_done_i        = 1'b1;
        bc_branch_flag_i = flag;
        bc_branch_dnpc_i = dnpc;
        trap_valid_i     = trap;
        trap_pc_i        = tpc;
        halt_i           = hlt;
        tick();
        ex_done_i        = 1'b0;
        bc_branch_flag_i = 1'b0;
        trap_valid_i     = 1'b0;
        halt_i           = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_valid", {63'd0, if_req_valid_o}, 64'd0);
        chk("rst_addr", if_req_addr_o, RST_PC);
        chk("rst_instret", instret_o, 64'd0);
        chk("rst_retire", {63'd0, retire_o}, 64'd0);
        chk("rst_halted", {63'd0, halted_o}, 64'd0);
        chk("rst_fault", {63'd0, fault_o}, 64'd0);
        chk("rst_fault_pc", fault_pc_o, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", {63'd0, if_req_valid_o}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; if_req_ready_i = 1'b0; if_rsp_valid_i = 1'b0; if_rsp_inst_i = '0;
        if_rsp_err_i = 1'b0; ex_done_i = 1'b0; bc_branch_flag_i = 1'b0; bc_branch_dnpc_i = '0;
        trap_valid_i = 1'b0; trap_pc_i = '0; halt_i = 1'b0;

        do_reset();
        chk("rst_id_valid", {63'd0, id_inst_valid_o}, 64'd0);
        chk("rst_retire_pc", retire_pc_o, 64'd0);

        // Three sequential instructions
        fetch(32'h0000_0013, 1'b0);
        chk("i1_id_valid", {63'd0, id_inst_valid_o}, 64'd1);
        chk("i1_id_inst", {32'd0, id_inst_o}, 64'h13);
        chk("i1_id_pc", id_pc_o, 64'h8000_0000);
        chk("i1_req_low", {63'd0, if_req_valid_o}, 64'd0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        chk("i1_retire", {63'd0, retire_o}, 64'd1);
        chk("i1_retire_pc", retire_pc_o, 64'h8000_0000);
        chk("i1_instret", instret_o, 64'd1);
        chk("i1_next_addr", if_req_addr_o, 64'h8000_0004);
        fetch(32'h0010_0093, 1'b0);
        chk("i2_retire_pulse_end", {63'd0, retire_o}, 64'd0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        chk("i2_instret", instret_o, 64'd2);
        chk("i2_next_addr", if_req_addr_o, 64'h8000_0008);
        fetch(32'h0020_0113, 1'b0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        chk("i3_instret", instret_o, 64'd3);
        chk("i3_retire_pc", retire_pc_o, 64'h8000_0008);
        chk("i3_next_addr", if_req_addr_o, 64'h8000_000C);

        // Taken and not-taken branches
        fetch(32'h0000_0063, 1'b0);
        execute(1'b1, 64'h8000_0100, 1'b0, 64'd0, 1'b0);
        chk("br_taken_addr", if_req_addr_o, 64'h8000_0100);
        chk("br_retire_pc", retire_pc_o, 64'h8000_000C);
        chk("br_instret", instret_o, 64'd4);
        fetch(32'h0000_0063, 1'b0);
        execute(1'b0, 64'h8000_0300, 1'b0, 64'd0, 1'b0);
        chk("br_not_taken_addr", if_req_addr_o, 64'h8000_0104);
        chk("br_nt_retire_pc", retire_pc_o, 64'h8000_0100);

        // Backpressure with spurious responses while in REQ
        if_rsp_inst_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            if_rsp_valid_i = i[0];
            tick();
            chk("bp_valid", {63'd0, if_req_valid_o}, 64'd1);
            chk("bp_addr", if_req_addr_o, 64'h8000_0104);
        end
        chk("bp_no_exec", {63'd0, id_inst_valid_o}, 64'd0);
        if_rsp_valid_i = 1'b1;
        if_req_ready_i = 1'b1;
        tick();
        if_req_ready_i = 1'b0;
        if_rsp_valid_i = 1'b0;
        chk("hs_rsp_ignored", {63'd0, id_inst_valid_o}, 64'd0);
        tick();
        chk("wait_idle", {63'd0, id_inst_valid_o}, 64'd0);
        if_rsp_valid_i = 1'b1;
        if_rsp_inst_i  = 32'h0030_0193;
        tick();
        if_rsp_valid_i = 1'b0;
        chk("wait_inst", {32'd0, id_inst_o}, 64'h0030_0193);

        // Trap beats branch
        execute(1'b1, 64'h8000_0100, 1'b1, 64'h8000_0200, 1'b0);
        chk("trap_addr", if_req_addr_o, 64'h8000_0200);
        chk("trap_retire_pc", retire_pc_o, 64'h8000_0104);
        chk("trap_instret", instret_o, 64'd6);
        fetch(32'h0000_0013, 1'b0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        chk("pre_halt_addr", if_req_addr_o, 64'h8000_0204);

        // Halt together with trap
        fetch(32'h0010_0073, 1'b0);
        execute(1'b1, 64'h8000_0100, 1'b1, 64'h8000_0200, 1'b1);
        chk("halt_halted", {63'd0, halted_o}, 64'd1);
        chk("halt_retire", {63'd0, retire_o}, 64'd1);
        chk("halt_retire_pc", retire_pc_o, 64'h8000_0204);
        chk("halt_pc", if_req_addr_o, 64'h8000_0200);
        chk("halt_instret", instret_o, 64'd8);
        chk("halt_req_low", {63'd0, if_req_valid_o}, 64'd0);
        chk("halt_no_fault", {63'd0, fault_o}, 64'd0);
        ex_done_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_hold", {63'd0, halted_o}, 64'd1);
            chk("halt_no_retire", {63'd0, retire_o}, 64'd0);
            chk("halt_id_low", {63'd0, id_inst_valid_o}, 64'd0);
        end
        ex_done_i = 1'b0;
        chk("halt_instret_hold", instret_o, 64'd8);

        // Fetch error at the third address
        do_reset();
        fetch(32'h0000_0013, 1'b0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        fetch(32'h0000_0013, 1'b0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        fetch(32'h0000_0013, 1'b1);
        chk("ferr_fault", {63'd0, fault_o}, 64'd1);
        chk("ferr_fault_pc", fault_pc_o, 64'h8000_0008);
        chk("ferr_halted", {63'd0, halted_o}, 64'd1);
        chk("ferr_no_retire", {63'd0, retire_o}, 64'd0);
        tick();
        tick();
        chk("ferr_sticky", {63'd0, fault_o}, 64'd1);
        chk("ferr_instret", instret_o, 64'd2);

        // Misaligned branch target
        do_reset();
        fetch(32'h0000_0063, 1'b0);
        execute(1'b1, 64'h8000_0102, 1'b0, 64'd0, 1'b0);
        chk("mis_retire", {63'd0, retire_o}, 64'd1);
        chk("mis_retire_pc", retire_pc_o, 64'h8000_0000);
        chk("mis_fault", {63'd0, fault_o}, 64'd1);
        chk("mis_fault_pc", fault_pc_o, 64'h8000_0102);
        chk("mis_halted", {63'd0, halted_o}, 64'd1);
        chk("mis_pc_kept", if_req_addr_o, 64'h8000_0000);
        chk("mis_instret", instret_o, 64'd1);

        // Reset while waiting for a response
        do_reset();
        fetch(32'h0000_0013, 1'b0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        if_req_ready_i = 1'b1;
        tick();
        if_req_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("rwait_addr", if_req_addr_o, RST_PC);
        chk("rwait_instret", instret_o, 64'd0);
        chk("rwait_valid", {63'd0, if_req_valid_o}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rwait_req", {63'd0, if_req_valid_o}, 64'd1);

        // Reset coinciding with ex_done suppresses the retire
        fetch(32'h0000_0013, 1'b0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        fetch(32'h0000_0013, 1'b0);
        ex_done_i = 1'b1;
        rst       = 1'b1;
        tick();
        ex_done_i = 1'b0;
        chk("rexec_no_retire", {63'd0, retire_o}, 64'd0);
        chk("rexec_instret", instret_o, 64'd0);
        chk("rexec_addr", if_req_addr_o, RST_PC);
        chk("rexec_id_low", {63'd0, id_inst_valid_o}, 64'd0);
        rst = 1'b0;
        #1;
        fetch(32'h0000_0013, 1'b0);
        execute(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        chk("restart_retire_pc", retire_pc_o, RST_PC);
        chk("restart_instret", instret_o, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
